// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
//    Shared definitions for the FIFO read-side drain controller.
//    - occ_e       : occupancy of the 2-entry output buffer (EMPTY/ONE/TWO)
//    - BUF_SLOTS   : number of buffer entries (pop credit limit)
//    - CNT_W       : width of the optional delivered-word counter
//    - occ_to_cnt  : occupancy state to entry count
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   localparam int BUF_SLOTS = 2;
   localparam int CNT_W     = 16;

   function automatic logic [1:0] occ_to_cnt(input occ_e occ);
      logic [1:0] cnt;
      case (occ)
         EMPTY:   cnt = 2'd0;
         ONE:     cnt = 2'd1;
         TWO:     cnt = 2'd2;
         default: cnt = 2'd0;
      endcase
      return cnt;
   endfunction

endpackage

// File: rtl/fifo_rd_drain_chk.sv
// fifo_rd_drain_chk
//    Simulation checker for the drain controller credit accounting.
//    Ports:
//       clk, rst_n  : read-domain clock and asynchronous active-low reset
//       occ         : current buffer occupancy
//       wr_en       : buffer capture strobe (inflight word arriving)
//       rd_en       : buffer read strobe (downstream handshake)
//       pop         : pop request towards the FIFO
//       fifo_empty  : FIFO empty flag
//       slots       : committed slots (occupancy + inflight - handshake)
module fifo_rd_drain_chk
   import fifo_rd_pkg::*;
(
   input logic       clk,
   input logic       rst_n,
   input occ_e       occ,
   input logic       wr_en,
   input logic       rd_en,
   input logic       pop,
   input logic       fifo_empty,
   input logic [2:0] slots
);

   // A word may only land in a full buffer when the head leaves the same edge.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(wr_en && !rd_en && (occ == TWO)));

   // Credit accounting never commits more words than there are entries.
   a_slots_max: assert property (@(posedge clk) disable iff (!rst_n)
      (slots <= 3'(BUF_SLOTS)));

   // A pop is never issued against an empty FIFO.
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && fifo_empty));

endmodule

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid
//    Two-entry in-order buffer. The head entry is a flop that directly drives
//    the stream data output, so data and valid are registered.
//    Ports:
//       i_clk, i_rst_n : clock, asynchronous active-low reset
//       i_wr_en        : capture i_wr_data behind the current contents
//       i_wr_data      : word to capture
//       i_rd_en        : head consumed this cycle (advance)
//       o_head_data    : head entry (0 after reset)
//       o_valid        : buffer non-empty
//       o_occ          : occupancy EMPTY/ONE/TWO
module fifo_rd_skid
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_head_data,
   output logic             o_valid,
   output occ_e             o_occ
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   occ_e             occ_q, occ_d;
   logic             valid_q, valid_d;

   // Next-state of the buffer: capture and/or advance, keeping pop order.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      case (occ_q)
         EMPTY: begin
            if (i_wr_en) begin
               head_d = i_wr_data;
               occ_d  = ONE;
            end else begin
               occ_d  = EMPTY;
            end
         end
         ONE: begin
            if (i_wr_en && i_rd_en) begin
               // head leaves, arriving word becomes the new head
               head_d = i_wr_data;
               occ_d  = ONE;
            end else if (i_wr_en) begin
               tail_d = i_wr_data;
               occ_d  = TWO;
            end else if (i_rd_en) begin
               occ_d  = EMPTY;
            end else begin
               occ_d  = ONE;
            end
         end
         TWO: begin
            if (i_rd_en) begin
               head_d = tail_q;
               if (i_wr_en) begin
                  tail_d = i_wr_data;
                  occ_d  = TWO;
               end else begin
                  occ_d  = ONE;
               end
            end else begin
               // a capture here is excluded by the pop credit logic
               occ_d  = TWO;
            end
         end
         default: begin
            occ_d = EMPTY;
         end
      endcase
      valid_d = (occ_d != EMPTY);
   end

   // Buffer state and entries.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= EMPTY;
         valid_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
         valid_q <= valid_d;
      end
   end

   assign o_head_data = head_q;
   assign o_valid     = valid_q;
   assign o_occ       = occ_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
//    Read-side drain controller: pops a registered-read FIFO (one-cycle
//    pop-to-data latency) and re-presents the words as a valid/ready stream.
//    Pops are credited against a 2-entry buffer so no word is lost under
//    backpressure while one word per cycle is sustained.
//    Ports:
//       i_clk, i_rst_n : read-domain clock, asynchronous active-low reset
//       i_fifo_empty   : FIFO empty flag (may be pessimistic)
//       o_fifo_pop     : pop request (combinational, 0 while in reset)
//       i_fifo_rdata   : FIFO read data, valid the cycle after a pop
//       o_valid        : stream word available (registered)
//       i_ready        : downstream accepts the word
//       o_data         : stream word (registered buffer head)
//       o_word_cnt     : delivered word counter, wraps at 16 bits
//                        (present only when FIFO_RD_WORD_CNT_EN is defined)
//    Optional feature macro: FIFO_RD_WORD_CNT_EN
module fifo_rd_drain
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_fifo_empty,
   output logic             o_fifo_pop,
   input  logic [WIDTH-1:0] i_fifo_rdata,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
`ifdef FIFO_RD_WORD_CNT_EN
   ,
   output logic [CNT_W-1:0] o_word_cnt
`endif
);

   logic       inflight_q, inflight_d;
   logic       valid_s;
   logic       hs_s;
   logic       pop_s;
   logic [2:0] slots_s;
   occ_e       occ_s;

   // Credit accounting: a pop is allowed only if its returning word is
   // guaranteed an entry. The i_ready term lets pops resume in the same
   // cycle backpressure is released.
   always_comb begin
      hs_s       = valid_s & i_ready;
      slots_s    = {1'b0, occ_to_cnt(occ_s)} + {2'b00, inflight_q} - {2'b00, hs_s};
      pop_s      = i_rst_n & ~i_fifo_empty & (slots_s < 3'(BUF_SLOTS));
      inflight_d = pop_s;
   end

   // Inflight flag: the word requested last cycle arrives on i_fifo_rdata now.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   fifo_rd_skid #(
      .WIDTH (WIDTH)
   ) u_skid (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_wr_en     (inflight_q),
      .i_wr_data   (i_fifo_rdata),
      .i_rd_en     (hs_s),
      .o_head_data (o_data),
      .o_valid     (valid_s),
      .o_occ       (occ_s)
   );

   fifo_rd_drain_chk u_chk (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .occ        (occ_s),
      .wr_en      (inflight_q),
      .rd_en      (hs_s),
      .pop        (pop_s),
      .fifo_empty (i_fifo_empty),
      .slots      (slots_s)
   );

   assign o_fifo_pop = pop_s;
   assign o_valid    = valid_s;

`ifdef FIFO_RD_WORD_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Delivered-word count, wraps naturally at the counter width.
   always_comb begin
      if (hs_s) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_word_cnt = cnt_q;
`endif

endmodule
